// File: rtl/umi_req_arbiter.sv
// Round-robin merge of two UMI requesters onto one registered out port; responses are
// steered back to their issuer via an in-order owner FIFO, zero-latency pass-through.
module umi_req_arbiter #(
   parameter int UW    = 256,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req0_valid,
   input  logic [UW-1:0]              req0_packet,
   output logic                       req0_ready,
   input  logic                       req1_valid,
   input  logic [UW-1:0]              req1_packet,
   output logic                       req1_ready,
   output logic                       umi_out_valid,
   output logic [UW-1:0]              umi_out_packet,
   input  logic                       umi_out_ready,
   input  logic                       umi_in_valid,
   input  logic [UW-1:0]              umi_in_packet,
   output logic                       umi_in_ready,
   output logic                       resp0_valid,
   output logic [UW-1:0]              resp0_packet,
   input  logic                       resp0_ready,
   output logic                       resp1_valid,
   output logic [UW-1:0]              resp1_packet,
   input  logic                       resp1_ready,
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output logic                       err_unexpected
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic             out_vld_q, out_vld_d;
   logic [UW-1:0]    out_pkt_q;
   logic             last_grant_q;
   logic [DEPTH-1:0] own_q;
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q;

   logic slot_free, can_issue, any_vld, grant, push, pop, empty, head, head_rdy;

   always_comb begin
      slot_free = !out_vld_q || umi_out_ready;
      can_issue = slot_free && (cnt_q < CW'(DEPTH));
      any_vld   = req0_valid || req1_valid;
      // Contested cycles go to whoever did not win last; otherwise the lone requester wins.
      grant     = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
      push      = can_issue && any_vld;

      empty     = (cnt_q == '0);
      head      = own_q[rd_ptr_q];
      head_rdy  = head ? resp1_ready : resp0_ready;
      pop       = umi_in_valid && !empty && head_rdy;

      out_vld_d = out_vld_q;
      if (push)
         out_vld_d = 1'b1;
      else if (umi_out_ready)
         out_vld_d = 1'b0;

      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + CW'(1);
      else if (pop && !push)
         cnt_d = cnt_q - CW'(1);
   end

   assign req0_ready     = can_issue && !grant;
   assign req1_ready     = can_issue && grant;
   assign umi_out_valid  = out_vld_q;
   assign umi_out_packet = out_pkt_q;
   // An empty tracker swallows stray responses so the return channel never wedges.
   assign umi_in_ready   = empty || head_rdy;
   assign resp0_valid    = umi_in_valid && !empty && !head;
   assign resp1_valid    = umi_in_valid && !empty && head;
   assign resp0_packet   = umi_in_packet;
   assign resp1_packet   = umi_in_packet;
   assign outstanding    = cnt_q;
   assign err_unexpected = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q    <= 1'b0;
         last_grant_q <= 1'b1;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         out_vld_q <= out_vld_d;
         cnt_q     <= cnt_d;
         if (push) begin
            last_grant_q <= grant;
            wr_ptr_q     <= wr_ptr_q + PW'(1);
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         if (umi_in_valid && empty)
            err_q <= 1'b1;
      end
   end

   // Data-path storage needs no reset: validity is carried by out_vld_q and cnt_q.
   always_ff @(posedge clk) begin
      if (push) begin
         out_pkt_q       <= grant ? req1_packet : req0_packet;
         own_q[wr_ptr_q] <= grant;
      end
   end

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Scoreboard bench for umi_req_arbiter: a reference model of grant, owner tracking and
// the out register predicts every handshake, checked on the falling clock edge.
module tb_umi_req_arbiter;

   localparam int UW    = 256;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [UW-1:0] req0_packet, req1_packet;
   logic          umi_out_valid, umi_out_ready;
   logic [UW-1:0] umi_out_packet;
   logic          umi_in_valid, umi_in_ready;
   logic [UW-1:0] umi_in_packet;
   logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [UW-1:0] resp0_packet, resp1_packet;
   logic [CW-1:0] outstanding;
   logic          err_unexpected;

   umi_req_arbiter #(.UW(UW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_packet(req0_packet), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_packet(req1_packet), .req1_ready(req1_ready),
      .umi_out_valid(umi_out_valid), .umi_out_packet(umi_out_packet),
      .umi_out_ready(umi_out_ready),
      .umi_in_valid(umi_in_valid), .umi_in_packet(umi_in_packet),
      .umi_in_ready(umi_in_ready),
      .resp0_valid(resp0_valid), .resp0_packet(resp0_packet), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_packet(resp1_packet), .resp1_ready(resp1_ready),
      .outstanding(outstanding), .err_unexpected(err_unexpected)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [UW-1:0] got, input logic [UW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference model state
   logic [UW-1:0] exp_out_q[$];
   logic          own_q[$];
   logic          grant_log[$];
   logic          out_vld_m = 1'b0;
   logic          lg_m      = 1'b1;
   logic          err_m     = 1'b0;

   always @(negedge clk) begin
      logic g, can, any, head, hrdy;
      if (rst) begin
         exp_out_q.delete();
         own_q.delete();
         out_vld_m = 1'b0;
         lg_m      = 1'b1;
         err_m     = 1'b0;
      end else begin
         chk("outstanding", UW'(outstanding), UW'(own_q.size()));
         chk("out_valid", UW'(umi_out_valid), UW'(out_vld_m));
         chk("err_sticky", UW'(err_unexpected), UW'(err_m));
         if (out_vld_m && exp_out_q.size() > 0)
            chk("out_packet", umi_out_packet, exp_out_q[0]);

         any = req0_valid || req1_valid;
         g   = (req0_valid && req1_valid) ? !lg_m : req1_valid;
         can = (!out_vld_m || umi_out_ready) && (own_q.size() < DEPTH);
         if (any) begin
            chk("req0_ready", UW'(req0_ready), UW'(can && !g));
            chk("req1_ready", UW'(req1_ready), UW'(can && g));
         end

         if (umi_in_valid) begin
            if (own_q.size() == 0) begin
               chk("drop_ready", UW'(umi_in_ready), UW'(1));
               chk("drop_nores", UW'({resp1_valid, resp0_valid}), UW'(0));
               err_m = 1'b1;
            end else begin
               head = own_q[0];
               hrdy = head ? resp1_ready : resp0_ready;
               chk("resp0_valid", UW'(resp0_valid), UW'(!head));
               chk("resp1_valid", UW'(resp1_valid), UW'(head));
               chk("in_ready", UW'(umi_in_ready), UW'(hrdy));
               chk("resp_packet", head ? resp1_packet : resp0_packet, umi_in_packet);
               if (hrdy)
                  void'(own_q.pop_front());
            end
         end

         if (out_vld_m && umi_out_ready && exp_out_q.size() > 0)
            void'(exp_out_q.pop_front());
         if (any && can) begin
            exp_out_q.push_back(g ? req1_packet : req0_packet);
            own_q.push_back(g);
            grant_log.push_back(g);
            lg_m      = g;
            out_vld_m = 1'b1;
         end else if (umi_out_ready) begin
            out_vld_m = 1'b0;
         end
      end
   end

   function automatic logic [UW-1:0] rnd_pkt();
      return {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int budget = 50;
      req0_valid = 1'b0; req1_valid = 1'b0;
      umi_out_ready = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
      while (own_q.size() > 0 && budget > 0) begin
         umi_in_valid  = 1'b1;
         umi_in_packet = rnd_pkt();
         cyc(1);
         budget--;
      end
      umi_in_valid = 1'b0;
      chk("drain_done", UW'(own_q.size()), UW'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_packet = '0; req1_packet = '0;
      umi_out_ready = 1'b1; umi_in_valid = 1'b0; umi_in_packet = '0;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      cyc(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_outstanding", UW'(outstanding), UW'(0));
      chk("rst_out_valid", UW'(umi_out_valid), UW'(0));
      chk("rst_err", UW'(err_unexpected), UW'(0));
      cyc(1);

      // contested requests every cycle, responses returned as soon as tracked
      grant_log.delete();
      for (int i = 0; i < 8; i++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         req0_packet = rnd_pkt(); req1_packet = rnd_pkt();
         umi_in_valid = (own_q.size() != 0);
         umi_in_packet = rnd_pkt();
         cyc(1);
      end
      drain();
      chk("rr_count", UW'(grant_log.size()), UW'(8));
      for (int i = 0; i < 8 && i < grant_log.size(); i++)
         chk("rr_order", UW'(grant_log[i]), UW'(i % 2));
      cyc(2);

      // single requester with downstream stalled for three cycles
      req0_valid = 1'b1; req0_packet = rnd_pkt();
      cyc(1);
      umi_out_ready = 1'b0; req0_packet = rnd_pkt();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_ready", UW'(req0_ready), UW'(0));
         cyc(1);
      end
      umi_out_ready = 1'b1;
      cyc(1);
      req0_valid = 1'b0;
      cyc(1);
      drain();
      cyc(2);

      // fill the tracker, then free one slot with a response
      req0_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req0_packet = rnd_pkt();
         cyc(1);
      end
      @(negedge clk);
      chk("full_outstanding", UW'(outstanding), UW'(DEPTH));
      chk("full_ready", UW'(req0_ready), UW'(0));
      cyc(1);
      umi_in_valid = 1'b1; umi_in_packet = rnd_pkt();
      cyc(1);
      umi_in_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_pop", UW'(req0_ready), UW'(1));
      cyc(1);
      drain();
      cyc(2);

      // owner order 1 then 0, requester 1 initially refusing its response
      req1_valid = 1'b1; req1_packet = rnd_pkt();
      cyc(1);
      req1_valid = 1'b0; req0_valid = 1'b1; req0_packet = rnd_pkt();
      cyc(1);
      req0_valid = 1'b0;
      resp1_ready = 1'b0; resp0_ready = 1'b1;
      umi_in_valid = 1'b1; umi_in_packet = rnd_pkt();
      cyc(2);
      @(negedge clk);
      chk("head_block", UW'(umi_in_ready), UW'(0));
      cyc(1);
      resp1_ready = 1'b1;
      @(negedge clk);
      chk("first_to_1", UW'({resp1_valid, resp0_valid}), UW'(2'b10));
      cyc(1);
      umi_in_packet = rnd_pkt();
      @(negedge clk);
      chk("then_to_0", UW'({resp1_valid, resp0_valid}), UW'(2'b01));
      cyc(1);
      umi_in_valid = 1'b0;
      cyc(2);

      // stray response with nothing outstanding
      umi_in_valid = 1'b1; umi_in_packet = rnd_pkt();
      @(negedge clk);
      chk("stray_ready", UW'(umi_in_ready), UW'(1));
      cyc(1);
      umi_in_valid = 1'b0;
      cyc(3);
      @(negedge clk);
      chk("err_held", UW'(err_unexpected), UW'(1));
      cyc(1);

      // reset with two outstanding and a packet held in the out register
      req0_valid = 1'b1; req0_packet = rnd_pkt();
      cyc(1);
      req0_packet = rnd_pkt();
      cyc(1);
      req0_valid = 1'b0; umi_out_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_outst", UW'(outstanding), UW'(2));
      chk("pre_rst_vld", UW'(umi_out_valid), UW'(1));
      cyc(1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_outst", UW'(outstanding), UW'(0));
      chk("post_rst_vld", UW'(umi_out_valid), UW'(0));
      chk("post_rst_err", UW'(err_unexpected), UW'(0));
      cyc(1);
      umi_out_ready = 1'b1;
      umi_in_valid = 1'b1; umi_in_packet = rnd_pkt();
      cyc(1);
      umi_in_valid = 1'b0;
      @(negedge clk);
      chk("late_resp_err", UW'(err_unexpected), UW'(1));
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
